// File: rtl/pll_reset_sequencer.sv
// Staged reset release after PLL lock: PSRAM domain first, then HDMI video once PSRAM init completes.
// Optional macro LOCK_GLITCH_FILTER_EN: lock loss is declared only after 4 consecutive low lock_s cycles.
`timescale 1ns/1ps
module pll_reset_sequencer #(
  parameter int STABLE_CYCLES = 1024,
  parameter int PSRAM_TIMEOUT = 20000,
  parameter int STAGE_GAP     = 16,
  parameter int CNT_W         = 16
) (
  input  logic       clkin,
  input  logic       reset_n,
  input  logic       lock,
  input  logic       psram_init_done,
  output logic       psram_rst_n,
  output logic       video_rst_n,
  output logic       sys_ready,
  output logic       init_fault,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    PSRAM_INIT,
    GAP,
    RUN
  } state_t;

  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(PSRAM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             lock_meta;
  logic             lock_s;
  logic             lock_lost;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= lock;
      lock_s    <= lock_meta;
    end
  end

`ifdef LOCK_GLITCH_FILTER_EN
  logic [1:0] low_cnt;

  // Counts consecutive low lock_s cycles, saturating; the 4th low cycle is the loss.
  always_ff @(posedge clkin) begin
    if (!reset_n)
      low_cnt <= 2'd0;
    else if (lock_s)
      low_cnt <= 2'd0;
    else if (low_cnt != 2'd3)
      low_cnt <= low_cnt + 2'd1;
  end

  assign lock_lost = !lock_s && (low_cnt == 2'd3);
`else
  assign lock_lost = !lock_s;
`endif

  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      state         <= WAIT_LOCK;
      counter       <= '0;
      psram_rst_n   <= 1'b0;
      video_rst_n   <= 1'b0;
      sys_ready     <= 1'b0;
      init_fault    <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else if (lock_lost && (state inside {PSRAM_INIT, GAP, RUN})) begin
      // Loss outranks any same-cycle done, timeout or gap expiry.
      state       <= WAIT_LOCK;
      counter     <= '0;
      psram_rst_n <= 1'b0;
      video_rst_n <= 1'b0;
      sys_ready   <= 1'b0;
      if (lock_loss_cnt != 8'hFF)
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end else begin
      case (state)
        WAIT_LOCK: begin
          // The first lock_s-high cycle counts as stable cycle zero.
          counter <= '0;
          if (lock_s) begin
            state   <= STABLE;
            counter <= CNT_W'(1);
          end
        end
        STABLE: begin
          if (lock_lost) begin
            state   <= WAIT_LOCK;
            counter <= '0;
          end else if (counter >= STABLE_LAST) begin
            // A filtered glitch may still be in progress; release only on a good lock.
            if (lock_s) begin
              state       <= PSRAM_INIT;
              counter     <= '0;
              psram_rst_n <= 1'b1;
            end
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        PSRAM_INIT: begin
          if (psram_init_done) begin
            state   <= GAP;
            counter <= '0;
          end else if (counter == TIMEOUT_LAST) begin
            state       <= WAIT_LOCK;
            counter     <= '0;
            psram_rst_n <= 1'b0;
            init_fault  <= 1'b1;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        GAP: begin
          if (counter == GAP_LAST) begin
            if (lock_s) begin
              state       <= RUN;
              video_rst_n <= 1'b1;
              sys_ready   <= 1'b1;
            end
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state   <= WAIT_LOCK;
          counter <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: tasks queue timed output expectations, a negedge monitor pops and checks them.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

  localparam int STABLE_CYCLES = 8;
  localparam int PSRAM_TIMEOUT = 20;
  localparam int STAGE_GAP     = 4;
`ifdef LOCK_GLITCH_FILTER_EN
  localparam int FX = 3;
`else
  localparam int FX = 0;
`endif
  localparam int LOW       = FX + 1;                        // shortest lock-low pulse that is a loss
  localparam int PSRAM_LAT = 2 + STABLE_CYCLES;             // lock driven -> psram_rst_n high
  localparam int VIDEO_LAT = PSRAM_LAT + 1 + STAGE_GAP;     // lock driven -> video_rst_n high (done tied 1)

  logic       clkin = 1'b0;
  logic       reset_n = 1'b0;
  logic       lock = 1'b0;
  logic       psram_init_done = 1'b0;
  logic       psram_rst_n, video_rst_n, sys_ready, init_fault;
  logic [7:0] lock_loss_cnt;

  pll_reset_sequencer #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .PSRAM_TIMEOUT(PSRAM_TIMEOUT),
    .STAGE_GAP(STAGE_GAP),
    .CNT_W(16)
  ) dut (
    .clkin(clkin),
    .reset_n(reset_n),
    .lock(lock),
    .psram_init_done(psram_init_done),
    .psram_rst_n(psram_rst_n),
    .video_rst_n(video_rst_n),
    .sys_ready(sys_ready),
    .init_fault(init_fault),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #4 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc++;

  typedef struct {
    string      name;
    int         at;
    logic       p, v, r, f;
    logic [7:0] c;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   armed = 0;
  int   cnt_model = 0;

  function automatic void expect_at(input string name, input int at, input logic p, input logic v,
                                    input logic r, input logic f, input int c);
    exp_t e;
    e.name = name; e.at = at; e.p = p; e.v = v; e.r = r; e.f = f; e.c = 8'(c);
    sb.push_back(e);
  endfunction

  always @(negedge clkin) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at < cyc) begin
      e = sb.pop_front();
      total++; bad++;
      $display("FAIL %s: expectation for cycle %0d never compared (now %0d)", e.name, e.at, cyc);
    end
    while (sb.size() > 0 && sb[0].at == cyc) begin
      e = sb.pop_front();
      total++;
      if ({psram_rst_n, video_rst_n, sys_ready, init_fault, lock_loss_cnt} !== {e.p, e.v, e.r, e.f, e.c}) begin
        bad++;
        $display("FAIL %s @%0d: got psram=%b video=%b ready=%b fault=%b cnt=%0d, want psram=%b video=%b ready=%b fault=%b cnt=%0d",
                 e.name, cyc, psram_rst_n, video_rst_n, sys_ready, init_fault, lock_loss_cnt,
                 e.p, e.v, e.r, e.f, e.c);
      end
    end
    if (armed) begin
      total++;
      if (video_rst_n === 1'b1 && psram_rst_n !== 1'b1) begin
        bad++;
        $display("FAIL invariant @%0d: video_rst_n=1 with psram_rst_n=%b, want 1", cyc, psram_rst_n);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) tick(1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    lock = 1'b0;
    psram_init_done = 1'b0;
    tick(2);
    reset_n = 1'b1;
    cnt_model = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({psram_rst_n, video_rst_n, sys_ready, init_fault, lock_loss_cnt} !== 12'h000) begin
      bad++;
      $display("FAIL reset_values: got psram=%b video=%b ready=%b fault=%b cnt=%0d, want all 0",
               psram_rst_n, video_rst_n, sys_ready, init_fault, lock_loss_cnt);
    end
    armed = 1;
  endtask

  task automatic test_release();
    int l;
    do_reset();
    psram_init_done = 1'b1;
    lock = 1'b1;
    l = cyc;
    expect_at("rel_pre",   l + PSRAM_LAT - 1, 0, 0, 0, 0, 0);
    expect_at("rel_psram", l + PSRAM_LAT,     1, 0, 0, 0, 0);
    expect_at("rel_vpre",  l + VIDEO_LAT - 1, 1, 0, 0, 0, 0);
    expect_at("rel_run",   l + VIDEO_LAT,     1, 1, 1, 0, 0);
    wait_until(l + VIDEO_LAT + 1);
    total++;
    if (sys_ready !== 1'b1 || lock_loss_cnt !== 8'd0) begin
      bad++;
      $display("FAIL rel_final: got ready=%b cnt=%0d, want ready=1 cnt=0", sys_ready, lock_loss_cnt);
    end
  endtask

  task automatic test_stable_glitch();
    int l, rel;
    do_reset();
    psram_init_done = 1'b1;
    lock = 1'b1;
    l = cyc;
    // lock_s is low for exactly one cycle while the stable counter reads 5
    rel = (FX != 0) ? l + PSRAM_LAT : l + PSRAM_LAT + 6;
    expect_at("glitch_pre",   rel - 1, 0, 0, 0, 0, 0);
    expect_at("glitch_psram", rel,     1, 0, 0, 0, 0);
    wait_until(l + 5);
    lock = 1'b0;
    tick(1);
    lock = 1'b1;
    wait_until(rel + 1);
  endtask

  task automatic test_timeout();
    int l, t, r, v;
    do_reset();
    psram_init_done = 1'b0;
    lock = 1'b1;
    l = cyc;
    t = l + PSRAM_LAT + PSRAM_TIMEOUT;
    r = t + STABLE_CYCLES;
    v = r + 1 + STAGE_GAP;
    expect_at("to_pre",     t - 1, 1, 0, 0, 0, 0);
    expect_at("to_fault",   t,     0, 0, 0, 1, 0);
    expect_at("to_retry0",  r - 1, 0, 0, 0, 1, 0);
    expect_at("to_retry1",  r,     1, 0, 0, 1, 0);
    expect_at("to_vpre",    v - 1, 1, 0, 0, 1, 0);
    expect_at("to_run",     v,     1, 1, 1, 1, 0);
    wait_until(t + 2);
    psram_init_done = 1'b1;
    wait_until(v + 1);
  endtask

  task automatic test_lock_loss_run();
    int d, k1, rel;
    for (int i = 0; i < 300; i++) begin
      d = cyc;
      k1 = (cnt_model == 255) ? 255 : cnt_model + 1;
      lock = 1'b0;
      expect_at("loss_hold",  d + 2 + FX, 1, 1, 1, 1, cnt_model);
      expect_at("loss_drop",  d + 3 + FX, 0, 0, 0, 1, k1);
      rel = d + LOW + VIDEO_LAT;
      expect_at("loss_rerun", rel,        1, 1, 1, 1, k1);
      cnt_model = k1;
      tick(LOW);
      lock = 1'b1;
      wait_until(rel + 1);
    end
    total++;
    if (lock_loss_cnt !== 8'd255) begin
      bad++;
      $display("FAIL loss_saturate: got cnt=%0d, want 255", lock_loss_cnt);
    end
  endtask

  task automatic test_reset_in_run();
    int e;
    total++;
    if (init_fault !== 1'b1 || sys_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre: got fault=%b ready=%b, want fault=1 ready=1", init_fault, sys_ready);
    end
    reset_n = 1'b0;
    e = cyc + 1;
    expect_at("rst_run", e, 0, 0, 0, 0, 0);
    tick(1);
    reset_n = 1'b1;
    cnt_model = 0;
    wait_until(e + 1);
  endtask

  task automatic test_gap_loss();
    int l, x;
    do_reset();
    psram_init_done = 1'b1;
    lock = 1'b1;
    l = cyc;
    x = l + VIDEO_LAT;   // edge where the gap would expire
    expect_at("gap_pre",   x - 1, 1, 0, 0, 0, 0);
    expect_at("gap_loss",  x,     0, 0, 0, 0, 1);
    expect_at("gap_after", x + 1, 0, 0, 0, 0, 1);
    wait_until(x - 3 - FX);
    lock = 1'b0;
    tick(LOW);
    lock = 1'b1;
    wait_until(x + 2);
  endtask

`ifdef LOCK_GLITCH_FILTER_EN
  task automatic test_glitch_filter();
    int l, d;
    do_reset();
    psram_init_done = 1'b1;
    lock = 1'b1;
    l = cyc;
    expect_at("filt_run", l + VIDEO_LAT, 1, 1, 1, 0, 0);
    wait_until(l + VIDEO_LAT + 1);
    d = cyc;
    for (int i = 1; i <= 8; i++) expect_at("filt_short", d + i, 1, 1, 1, 0, 0);
    lock = 1'b0;
    tick(3);
    lock = 1'b1;
    wait_until(d + 9);
    d = cyc;
    expect_at("filt_hold", d + 5, 1, 1, 1, 0, 0);
    expect_at("filt_drop", d + 6, 0, 0, 0, 0, 1);
    lock = 1'b0;
    tick(4);
    lock = 1'b1;
    wait_until(d + 7);
  endtask
`endif

  initial begin
    test_reset();
    test_release();
    test_stable_glitch();
    test_timeout();
    test_lock_loss_run();
    test_reset_in_run();
    test_gap_loss();
`ifdef LOCK_GLITCH_FILTER_EN
    test_glitch_filter();
`endif
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
